apb_gpio_slave: RTL and testbench

APB completer that owns the GPIO register file and answers transfers issued by the team's APB master on its PSEL1 line. It holds output data and direction registers, synchronizes pad inputs, and inserts a parameterized number of wait states through `pready`. Outputs drive the GPIO pad ring directly.

---
 rtl/apb_pkg.sv | 19 +
 rtl/gpio_sync2.sv | 23 ++
 rtl/apb_gpio_slave.sv | 153 +++++++++++++++
 tb/tb_apb_gpio_slave.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, GPIO register offsets and bus widths.
package apb_pkg;

  localparam int unsigned AddrW = 5;
  localparam int unsigned DataW = 32;

  typedef enum logic {
    StIdle,
    StAccess
  } apb_state_e;

  // Register offsets, indexed by paddr[4:2]
  localparam logic [2:0] OffDataOut = 3'd0;
  localparam logic [2:0] OffDir     = 3'd1;
  localparam logic [2:0] OffDataIn  = 3'd2;
  localparam logic [2:0] OffIrqEn   = 3'd3;
  localparam logic [2:0] OffIrqStat = 3'd4;

endpackage

// File: rtl/gpio_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous pad inputs.
module gpio_sync2 #(
  parameter int unsigned Width = 1
) (
  input  logic             pclk,
  input  logic             Reset_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;

  always_ff @(posedge pclk or negedge Reset_n) begin
    if (!Reset_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/apb_gpio_slave.sv
// APB completer for the GPIO register file with configurable wait states.
// Optional interrupt registers and the irq port are enabled by defining APB_GPIO_IRQ_EN.
module apb_gpio_slave
  import apb_pkg::*;
#(
  parameter int unsigned GPIO_W      = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              pclk,
  input  logic              Reset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [AddrW-1:0]  paddr,
  input  logic [DataW-1:0]  pwdata,
  output logic [DataW-1:0]  prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe
`ifdef APB_GPIO_IRQ_EN
  ,
  output logic              irq
`endif
);

  apb_state_e        state_q;
  logic [3:0]        cnt_q;
  logic [2:0]        addr_q;
  logic              pwrite_q;
  logic [DataW-1:0]  pwdata_q;
  logic [GPIO_W-1:0] data_out_q;
  logic [GPIO_W-1:0] dir_q;
  logic [GPIO_W-1:0] data_in;
  logic              complete;
  logic              commit;
  logic              dec_err;
  logic [DataW-1:0]  rdata;

  // Byte-lane bits of the address carry no meaning for word registers
  logic unused_paddr;
  assign unused_paddr = ^paddr[1:0];

  gpio_sync2 #(
    .Width(GPIO_W)
  ) u_sync (
    .pclk   (pclk),
    .Reset_n(Reset_n),
    .d      (gpio_in),
    .q      (data_in)
  );

  assign pready   = (state_q == StAccess) && (cnt_q == 4'd0);
  assign complete = psel && penable && pready;
  assign commit   = complete && pwrite_q && !dec_err;

  always_ff @(posedge pclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      addr_q   <= 3'd0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (psel && !penable) begin
            state_q  <= StAccess;
            addr_q   <= paddr[4:2];
            pwrite_q <= pwrite;
            pwdata_q <= pwdata;
            cnt_q    <= 4'(WAIT_STATES);
          end
        end
        StAccess: begin
          // Dropping psel before completion aborts with no side effects
          if (!psel || complete) begin
            state_q <= StIdle;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef APB_GPIO_IRQ_EN
  logic [GPIO_W-1:0] irq_en_q;
  logic [GPIO_W-1:0] irq_stat_q;
  logic [GPIO_W-1:0] irq_stat_d;
  logic [GPIO_W-1:0] irq_clr;
  logic [GPIO_W-1:0] data_in_prev_q;

  assign irq_clr    = (commit && addr_q == OffIrqStat) ? pwdata_q[GPIO_W-1:0] : '0;
  // A rising edge in the same cycle as a W1C clear keeps the bit set
  assign irq_stat_d = (irq_stat_q & ~irq_clr) | (data_in & ~data_in_prev_q);
  assign irq        = |(irq_stat_q & irq_en_q);

  always_ff @(posedge pclk or negedge Reset_n) begin
    if (!Reset_n) begin
      irq_en_q       <= '0;
      irq_stat_q     <= '0;
      data_in_prev_q <= '0;
    end else begin
      data_in_prev_q <= data_in;
      irq_stat_q     <= irq_stat_d;
      if (commit && addr_q == OffIrqEn) begin
        irq_en_q <= pwdata_q[GPIO_W-1:0];
      end
    end
  end
`endif

  always_comb begin
    rdata   = '0;
    dec_err = 1'b0;
    case (addr_q)
      OffDataOut: rdata = DataW'(data_out_q);
      OffDir:     rdata = DataW'(dir_q);
      OffDataIn: begin
        rdata   = DataW'(data_in);
        dec_err = pwrite_q;
      end
`ifdef APB_GPIO_IRQ_EN
      OffIrqEn:   rdata = DataW'(irq_en_q);
      OffIrqStat: rdata = DataW'(irq_stat_q);
`endif
      default:    dec_err = 1'b1;
    endcase
  end

  assign pslverr = pready && dec_err;
  assign prdata  = (pready && !pwrite_q && !dec_err) ? rdata : '0;

  always_ff @(posedge pclk or negedge Reset_n) begin
    if (!Reset_n) begin
      data_out_q <= '0;
      dir_q      <= '0;
    end else if (commit) begin
      case (addr_q)
        OffDataOut: data_out_q <= pwdata_q[GPIO_W-1:0];
        OffDir:     dir_q      <= pwdata_q[GPIO_W-1:0];
        default:    ;
      endcase
    end
  end

  assign gpio_out = data_out_q;
  assign gpio_oe  = dir_q;

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Directed, table-driven bench for apb_gpio_slave with two wait states per transfer.
module tb_apb_gpio_slave;

  localparam int unsigned GpioW = 32;
  localparam int unsigned Ws    = 2;
  localparam int          NVec  = 11;

  logic             pclk    = 1'b0;
  logic             Reset_n = 1'b0;
  logic             psel    = 1'b0;
  logic             penable = 1'b0;
  logic             pwrite  = 1'b0;
  logic [4:0]       paddr   = '0;
  logic [31:0]      pwdata  = '0;
  logic [31:0]      prdata;
  logic             pready;
  logic             pslverr;
  logic [GpioW-1:0] gpio_in = '0;
  logic [GpioW-1:0] gpio_out;
  logic [GpioW-1:0] gpio_oe;
`ifdef APB_GPIO_IRQ_EN
  logic             irq;
`endif

  apb_gpio_slave #(
    .GPIO_W     (GpioW),
    .WAIT_STATES(Ws)
  ) dut (
    .pclk    (pclk),
    .Reset_n (Reset_n),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
`ifdef APB_GPIO_IRQ_EN
    .irq     (irq),
`endif
    .gpio_oe (gpio_oe)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[NVec];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Runs setup and access phases; returns with the completion edge still ahead.
  task automatic apb_xfer(input logic wr, input logic [4:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic err, output int waits);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    waits   = 0;
    while (pready !== 1'b1 && waits < 20) begin
      @(negedge pclk);
      waits++;
    end
    rd  = prdata;
    err = pslverr;
    if (pready !== 1'b1) begin
      n_total++;
      $display("FAIL xfer_timeout: pready got %b required 1", pready);
    end
  endtask

  task automatic apb_idle();
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          waits;

    vecs[0]  = '{1'b0, 5'h00, 32'h0,         32'h0,         1'b0};
    vecs[1]  = '{1'b0, 5'h04, 32'h0,         32'h0,         1'b0};
    vecs[2]  = '{1'b1, 5'h00, 32'hA5A5_0F0F, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 5'h00, 32'h0,         32'hA5A5_0F0F, 1'b0};
    vecs[4]  = '{1'b1, 5'h04, 32'h0000_FFFF, 32'h0,         1'b0};
    vecs[5]  = '{1'b0, 5'h04, 32'h0,         32'h0000_FFFF, 1'b0};
    vecs[6]  = '{1'b0, 5'h1C, 32'h0,         32'h0,         1'b1};
`ifdef APB_GPIO_IRQ_EN
    vecs[7]  = '{1'b0, 5'h0C, 32'h0,         32'h0,         1'b0};
`else
    vecs[7]  = '{1'b0, 5'h0C, 32'h0,         32'h0,         1'b1};
`endif
    vecs[8]  = '{1'b0, 5'h14, 32'h0,         32'h0,         1'b1};
    vecs[9]  = '{1'b1, 5'h1C, 32'h1111_1111, 32'h0,         1'b1};
    vecs[10] = '{1'b0, 5'h03, 32'h0,         32'hA5A5_0F0F, 1'b0};

    // Reset state
    repeat (3) @(negedge pclk);
    check("rst_prdata", prdata, 32'h0);
    check("rst_pready", 32'(pready), 32'h0);
    check("rst_pslverr", 32'(pslverr), 32'h0);
    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_gpio_oe", gpio_oe, 32'h0);
    Reset_n = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, waits);
      check($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_pslverr", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_waits", i), 32'(waits), 32'(Ws));
      apb_idle();
    end
    check("dir_to_oe", gpio_oe, 32'h0000_FFFF);

    // Pins change only after the completion edge
    apb_xfer(1'b1, 5'h00, 32'h5A5A_1234, rd, err, waits);
    check("pin_before_commit", gpio_out, 32'hA5A5_0F0F);
    apb_idle();
    check("pin_after_commit", gpio_out, 32'h5A5A_1234);

    // Synchronized inputs, then a rejected write to DATA_IN
    @(negedge pclk);
    gpio_in = 32'h1234_5678;
    repeat (3) @(negedge pclk);
    apb_xfer(1'b0, 5'h08, 32'h0, rd, err, waits);
    check("data_in_rd", rd, 32'h1234_5678);
    check("data_in_err", 32'(err), 32'h0);
    apb_idle();
    apb_xfer(1'b1, 5'h08, 32'h0000_FFFF, rd, err, waits);
    check("data_in_wr_err", 32'(err), 32'h1);
    check("data_in_wr_rd", rd, 32'h0);
    apb_idle();
    apb_xfer(1'b0, 5'h08, 32'h0, rd, err, waits);
    check("data_in_kept", rd, 32'h1234_5678);
    apb_idle();

    // Back-to-back writes with no idle cycle between them
    apb_xfer(1'b1, 5'h00, 32'h0000_0011, rd, err, waits);
    apb_xfer(1'b1, 5'h04, 32'h0000_0022, rd, err, waits);
    check("b2b_waits", 32'(waits), 32'(Ws));
    apb_idle();
    check("b2b_out", gpio_out, 32'h0000_0011);
    check("b2b_oe", gpio_oe, 32'h0000_0022);

    // penable without a setup phase is ignored
    @(negedge pclk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'hBAD0_BAD0;
    repeat (3) @(negedge pclk);
    check("idle_penable_pready", 32'(pready), 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("idle_penable_out", gpio_out, 32'h0000_0011);

    // Abort: psel drops during the wait states
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'hDEAD_BEEF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    repeat (4) @(negedge pclk);
    check("abort_out", gpio_out, 32'h0000_0011);
    apb_xfer(1'b0, 5'h00, 32'h0, rd, err, waits);
    check("abort_then_rd", rd, 32'h0000_0011);
    check("abort_then_waits", 32'(waits), 32'(Ws));
    apb_idle();

    // Reset during a write's wait state
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'h0000_CAFE;
    @(negedge pclk);
    penable = 1'b1;
    Reset_n = 1'b0;
    psel = 1'b0; penable = 1'b0;
    #1;
    check("midrst_out", gpio_out, 32'h0);
    check("midrst_oe", gpio_oe, 32'h0);
    check("midrst_pready", 32'(pready), 32'h0);
    check("midrst_prdata", prdata, 32'h0);
    @(negedge pclk);
    Reset_n = 1'b1;
    repeat (2) @(negedge pclk);
    check("midrst_dropped", gpio_out, 32'h0);
    apb_xfer(1'b0, 5'h00, 32'h0, rd, err, waits);
    check("midrst_rd", rd, 32'h0);
    apb_idle();

`ifdef APB_GPIO_IRQ_EN
    @(negedge pclk);
    gpio_in = '0;
    repeat (4) @(negedge pclk);
    apb_xfer(1'b1, 5'h0C, 32'h0000_0001, rd, err, waits);
    apb_idle();
    apb_xfer(1'b1, 5'h10, 32'hFFFF_FFFF, rd, err, waits);
    apb_idle();
    check("irq_quiet", 32'(irq), 32'h0);
    gpio_in = 32'h0000_0001;
    repeat (3) @(negedge pclk);
    check("irq_set", 32'(irq), 32'h1);
    apb_xfer(1'b0, 5'h10, 32'h0, rd, err, waits);
    check("irq_stat_rd", rd, 32'h0000_0001);
    apb_idle();
    apb_xfer(1'b1, 5'h10, 32'h0000_0001, rd, err, waits);
    apb_idle();
    check("irq_cleared", 32'(irq), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
